mbox_tx_framer: RTL and testbench
=================================

// Module: mbox_tx_framer
// PURPOSE
//  - Downstream of the SFIFO/WISHBONE bridge: accepts the LSB-first MAILBOX byte stream (mbox_wr/mbox_do),
//    buffers it in a byte FIFO and returns full/almost-full/empty status to the bridge.
//  - Drains the FIFO as WOU frames {SYNC, LEN, PAYLOAD[LEN], CHK} onto a valid/ready byte link to the WOU tx.
// PARAMETERS
//  WOU_DW     8      byte width of MAILBOX data and tx link
//  AW         6      FIFO address width; DEPTH = 2**AW = 64 bytes
//  AFULL_TH   8      mbox_afull_o asserted when free slots <= AFULL_TH
//  MAX_PLD    32     max payload bytes per frame (1..DEPTH)
//  IDLE_TO    255    cycles without a write before a partial frame is flushed
//  SYNC_BYTE  8'h55  frame start byte
// PORTS
//  wb_clk_i      in   1        system clock (clk_500 domain)
//  wb_rst_i      in   1        reset; asynchronous, active-high
//  mbox_wr_i     in   1        write strobe for mbox_di
//  mbox_di       in   WOU_DW   MAILBOX byte
//  mbox_full_o   out  1        FIFO full (count == DEPTH)
//  mbox_afull_o  out  1        DEPTH-count <= AFULL_TH
//  mbox_empty_o  out  1        count == 0
//  tx_valid_o    out  1        tx_data_o valid
//  tx_data_o     out  WOU_DW   frame byte
//  tx_ready_i    in   1        downstream accepts byte when tx_valid_o & tx_ready_i
//  frame_cnt_o   out  16       frames completed, wraps 16'hFFFF -> 0
//  ovf_o         out  1        sticky: write attempted while full
// BEHAVIOUR
//  - Reset (async): FIFO pointers/count 0, empty=1, full=afull=0, tx_valid_o=0, tx_data_o=0,
//    frame_cnt_o=0, ovf_o=0, FSM=IDLE, idle timer 0. Reset mid-frame abandons the frame and discards buffered bytes.
//  - Write: accepted on mbox_wr_i & ~mbox_full_o; flags registered, update the cycle after the write/read.
//    mbox_wr_i while full: byte dropped, ovf_o <= 1 until reset; a same-cycle FIFO read does not rescue it.
//    Simultaneous accepted write and read: count unchanged.
//  - Idle timer: in IDLE with count>0, increments per cycle, saturates at IDLE_TO; cleared by any accepted write
//    or when count==0.
//  - FSM IDLE->SYNC->LEN->PLD->CHK->IDLE; one byte per state, advance only on tx handshake (PLD: per byte).
//    IDLE: launch when count >= MAX_PLD, or count>0 & timer==IDLE_TO; latch LEN = min(count,MAX_PLD);
//      tx_valid_o rises the cycle after launch condition with tx_data_o=SYNC_BYTE.
//    LEN: tx_data_o = LEN. PLD: tx_data_o = FIFO head (show-ahead); each handshake pops one byte and
//      decrements remaining; after LEN-th byte go CHK. CHK: tx_data_o = checksum; on handshake
//      frame_cnt_o += 1, tx_valid_o drops for >=1 cycle (IDLE), next frame may launch from IDLE.
//  - tx_data_o/tx_valid_o held stable while tx_valid_o & ~tx_ready_i; no byte lost or duplicated under stall.
//  - Writes continue to be accepted during a frame; they land in later frames only (LEN is latched).
//  - Checksum (default): 8-bit two's complement so (LEN + sum(PAYLOAD) + CHK) mod 256 == 0; SYNC excluded.
// CONFIGURATION
//  - MBOX_TX_CRC8_EN defined: CHK = CRC-8, poly x^8+x^2+x+1 (0x07), init 8'h00, no reflection, no final XOR,
//    computed over LEN then PAYLOAD MSB-first per byte.
//  - Not defined: additive checksum above; CRC logic absent.
// TESTING
//  1. Reset, write 4 bytes 01 02 03 04, tx_ready_i=1, wait IDLE_TO -> frame 55 04 01 02 03 04 F2; frame_cnt_o=1; empty=1.
//  2. Burst 40 bytes 00..27 back-to-back, ready=1 -> first frame LEN=20h, payload 00..1F immediately (no timeout);
//     remaining 8 bytes flushed as LEN=08 after IDLE_TO.
//  3. Frame in flight, tx_ready_i toggled 1/0 every cycle -> byte sequence identical to case 1, data stable while stalled.
//  4. tx_ready_i=0, write 65 bytes -> full=1 after 64th, afull=1 at count 56, 65th dropped, ovf_o=1 sticky.
//  5. Assert wb_rst_i during PLD of a 10-byte frame -> tx_valid_o=0 and empty=1 immediately; no resumed frame after release.
//  6. MBOX_TX_CRC8_EN, payload 01 02 03 04 -> CHK = CRC-8/0x07 of {04,01,02,03,04} checked against bench model.

Source files
------------

// File: rtl/mbox_tx_framer.sv
// MAILBOX byte FIFO plus WOU frame builder: {SYNC, LEN, PAYLOAD[LEN], CHK} on a valid/ready byte link.
// Define MBOX_TX_CRC8_EN to replace the additive checksum with CRC-8 (poly 0x07) over LEN and PAYLOAD.
module mbox_tx_framer #(
    parameter int                WOU_DW    = 8,
    parameter int                AW        = 6,
    parameter int                AFULL_TH  = 8,
    parameter int                MAX_PLD   = 32,
    parameter int                IDLE_TO   = 255,
    parameter logic [WOU_DW-1:0] SYNC_BYTE = 8'h55
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              mbox_wr_i,
    input  logic [WOU_DW-1:0] mbox_di,
    output logic              mbox_full_o,
    output logic              mbox_afull_o,
    output logic              mbox_empty_o,
    output logic              tx_valid_o,
    output logic [WOU_DW-1:0] tx_data_o,
    input  logic              tx_ready_i,
    output logic [15:0]       frame_cnt_o,
    output logic              ovf_o
);

    localparam int DEPTH = 1 << AW;
    localparam int CW    = AW + 1;
    localparam int TW    = $clog2(IDLE_TO + 1);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_PLD);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);
    localparam logic [TW-1:0] TO_C    = TW'(IDLE_TO);

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_LEN, S_PLD, S_CHK} state_t;

    state_t            state;
    logic [WOU_DW-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr, rd_ptr_inc;
    logic [CW-1:0]     count, count_nxt, free_nxt, pld_len, remain;
    logic [TW-1:0]     idle_tmr;
    logic [WOU_DW-1:0] len_q, len_nxt, acc, acc_nxt, acc_init, chk_val;
    logic              wr_acc, pop, hs, launch;

    assign hs         = tx_valid_o & tx_ready_i;
    assign wr_acc     = mbox_wr_i & ~mbox_full_o;
    assign pop        = (state == S_PLD) & hs;
    assign rd_ptr_inc = rd_ptr + 1'b1;

    always_comb begin
        count_nxt = count;
        if (wr_acc & ~pop)
            count_nxt = count + 1'b1;
        else if (~wr_acc & pop)
            count_nxt = count - 1'b1;
    end

    assign free_nxt = DEPTH_C - count_nxt;
    assign pld_len  = (count >= MAX_C) ? MAX_C : count;
    assign len_nxt  = WOU_DW'(pld_len);
    assign launch   = (state == S_IDLE) &
                      ((count >= MAX_C) | ((count != '0) & (idle_tmr == TO_C)));

`ifdef MBOX_TX_CRC8_EN
    function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++)
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    assign acc_init = crc8_upd(8'h00, len_nxt);
    assign acc_nxt  = crc8_upd(acc, tx_data_o);
    assign chk_val  = acc_nxt;
`else
    // Running sum of LEN and payload; CHK is its negation so the frame sums to zero.
    assign acc_init = len_nxt;
    assign acc_nxt  = acc + tx_data_o;
    assign chk_val  = '0 - acc_nxt;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wr_acc)
            mem[wr_ptr] <= mbox_di;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            mbox_empty_o <= 1'b1;
            mbox_full_o  <= 1'b0;
            mbox_afull_o <= 1'b0;
            ovf_o        <= 1'b0;
            idle_tmr     <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr_inc;
            count        <= count_nxt;
            mbox_full_o  <= (count_nxt == DEPTH_C);
            mbox_afull_o <= (free_nxt <= AFULL_C);
            mbox_empty_o <= (count_nxt == '0);
            if (mbox_wr_i & mbox_full_o)
                ovf_o <= 1'b1;
            // Timer only runs while idle, so a backlog left after a frame waits a full timeout.
            if (wr_acc || count == '0)
                idle_tmr <= '0;
            else if (state == S_IDLE && idle_tmr != TO_C)
                idle_tmr <= idle_tmr + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= S_IDLE;
            tx_valid_o  <= 1'b0;
            tx_data_o   <= '0;
            len_q       <= '0;
            remain      <= '0;
            acc         <= '0;
            frame_cnt_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        state      <= S_SYNC;
                        tx_valid_o <= 1'b1;
                        tx_data_o  <= SYNC_BYTE;
                        len_q      <= len_nxt;
                        remain     <= pld_len;
                        acc        <= acc_init;
                    end
                end
                S_SYNC: begin
                    if (hs) begin
                        state     <= S_LEN;
                        tx_data_o <= len_q;
                    end
                end
                S_LEN: begin
                    if (hs) begin
                        state     <= S_PLD;
                        tx_data_o <= mem[rd_ptr];
                    end
                end
                S_PLD: begin
                    // Next head is always within the latched LEN, so it is already written.
                    if (hs) begin
                        acc    <= acc_nxt;
                        remain <= remain - 1'b1;
                        if (remain == CW'(1)) begin
                            state     <= S_CHK;
                            tx_data_o <= chk_val;
                        end else begin
                            tx_data_o <= mem[rd_ptr_inc];
                        end
                    end
                end
                S_CHK: begin
                    if (hs) begin
                        state       <= S_IDLE;
                        tx_valid_o  <= 1'b0;
                        tx_data_o   <= '0;
                        frame_cnt_o <= frame_cnt_o + 1'b1;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    tx_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mbox_tx_framer.sv
// Directed bench for mbox_tx_framer: table of single-frame vectors plus burst, overflow and reset sequences.
// Build with MBOX_TX_CRC8_EN to check the CRC-8 checksum variant against the local model.
module tb_mbox_tx_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr = 1'b0;
    logic [7:0]  di = 8'h00;
    logic        ready = 1'b0;
    logic        full, afull, empty, tx_valid, ovf;
    logic [7:0]  tx_data;
    logic [15:0] frame_cnt;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [7:0]  q[$];
    bit          seen = 1'b0;

    mbox_tx_framer dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .mbox_wr_i    (wr),
        .mbox_di      (di),
        .mbox_full_o  (full),
        .mbox_afull_o (afull),
        .mbox_empty_o (empty),
        .tx_valid_o   (tx_valid),
        .tx_data_o    (tx_data),
        .tx_ready_i   (ready),
        .frame_cnt_o  (frame_cnt),
        .ovf_o        (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] d);
        wr = 1'b1;
        di = d;
        tick();
        wr = 1'b0;
    endtask

    function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++)
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    function automatic logic [7:0] qb(input int i);
        if (i < q.size())
            return q[i];
        return 8'hxx;
    endfunction

    // Handshake collector and stall-hold checker, sampled mid-cycle.
    initial begin : mon
        logic       pv, pr;
        logic [7:0] pd;
        pv = 1'b0; pr = 1'b0; pd = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr)
                    chk("stall_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, pd});
                if (tx_valid)
                    seen = 1'b1;
                if (tx_valid && ready)
                    q.push_back(tx_data);
                pv = tx_valid; pr = ready; pd = tx_data;
            end
        end
    end

    task automatic wait_frames(input int target, input bit toggle, input int budget);
        int k = 0;
        while (int'(frame_cnt) != target && k < budget) begin
            if (toggle)
                ready = ~ready;
            tick();
            k++;
        end
        chk("frame_done", 32'(frame_cnt), 32'(target));
    endtask

    task automatic check_frame(input int base, input int n, input logic [7:0] first,
                               input logic [7:0] chk_tab);
        logic [7:0] exp_chk, b;
`ifdef MBOX_TX_CRC8_EN
        exp_chk = crc8_upd(8'h00, 8'(n));
        for (int i = 0; i < n; i++)
            exp_chk = crc8_upd(exp_chk, first + 8'(i));
`else
        exp_chk = chk_tab;
`endif
        chk("sync", 32'(qb(base)), 32'h55);
        chk("len", 32'(qb(base + 1)), 32'(n));
        for (int i = 0; i < n; i++) begin
            b = first + 8'(i);
            chk("payload", 32'(qb(base + 2 + i)), 32'(b));
        end
        chk("chk", 32'(qb(base + 2 + n)), 32'(exp_chk));
    endtask

    typedef struct {
        int         n;
        logic [7:0] first;
        bit         toggle;
        logic [7:0] chk;
    } vec_t;

    vec_t tab[6];

    initial begin
        int base, k;
        tab[0] = '{4,  8'h01, 1'b0, 8'hF2};
        tab[1] = '{1,  8'hFF, 1'b0, 8'h00};
        tab[2] = '{4,  8'h01, 1'b1, 8'hF2};
        tab[3] = '{3,  8'h10, 1'b1, 8'hCA};
        tab[4] = '{32, 8'h00, 1'b0, 8'hF0};
        tab[5] = '{32, 8'hE0, 1'b1, 8'hF0};

        repeat (3) tick();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_afull", 32'(afull), 32'd0);
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_fcnt", 32'(frame_cnt), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            ready = 1'b1;
            q.delete();
            base = int'(frame_cnt);
            for (int i = 0; i < tab[v].n; i++)
                wr_byte(tab[v].first + 8'(i));
            if (tab[v].n >= 32) begin
                chk("launch_pre", 32'(tx_valid), 32'd0);
                tick();
                chk("launch_full", 32'(tx_valid), 32'd1);
            end else begin
                repeat (255) tick();
                chk("timeout_pre", 32'(tx_valid), 32'd0);
                tick();
                chk("timeout_fire", 32'(tx_valid), 32'd1);
            end
            wait_frames(base + 1, tab[v].toggle, 400);
            ready = 1'b1;
            chk("frame_bytes", 32'(q.size()), 32'(tab[v].n + 3));
            check_frame(0, tab[v].n, tab[v].first, tab[v].chk);
            chk("post_empty", 32'(empty), 32'd1);
            chk("post_valid", 32'(tx_valid), 32'd0);
        end

        // 40-byte burst: full frame at once, 8-byte remainder after timeout.
        ready = 1'b1;
        q.delete();
        base = int'(frame_cnt);
        for (int i = 0; i < 40; i++)
            wr_byte(8'(i));
        wait_frames(base + 2, 1'b0, 800);
        chk("burst_bytes", 32'(q.size()), 32'd46);
        check_frame(0, 32, 8'h00, 8'hF0);
        check_frame(35, 8, 8'h20, 8'hDC);

        // Fill with link stalled: afull/full thresholds and sticky overflow.
        ready = 1'b0;
        q.delete();
        base = int'(frame_cnt);
        for (int i = 0; i < 65; i++) begin
            wr_byte(8'(i));
            case (i + 1)
                1:  chk("fill_empty", 32'(empty), 32'd0);
                55: chk("afull_55", 32'(afull), 32'd0);
                56: chk("afull_56", 32'(afull), 32'd1);
                63: chk("full_63", 32'(full), 32'd0);
                64: begin
                    chk("full_64", 32'(full), 32'd1);
                    chk("ovf_64", 32'(ovf), 32'd0);
                end
                65: chk("ovf_65", 32'(ovf), 32'd1);
                default: ;
            endcase
        end
        repeat (5) tick();
        chk("ovf_sticky", 32'(ovf), 32'd1);
        ready = 1'b1;
        wait_frames(base + 2, 1'b0, 300);
        repeat (3) tick();
        chk("drain_bytes", 32'(q.size()), 32'd70);
        check_frame(0, 32, 8'h00, 8'hF0);
        check_frame(35, 32, 8'h20, 8'hF0);
        chk("drain_empty", 32'(empty), 32'd1);
        chk("ovf_kept", 32'(ovf), 32'd1);

        // Reset in the middle of the payload of a 10-byte frame.
        q.delete();
        for (int i = 0; i < 10; i++)
            wr_byte(8'hA0 + 8'(i));
        k = 0;
        while (q.size() < 4 && k < 400) begin
            tick();
            k++;
        end
        chk("mid_pld_reached", 32'(q.size() >= 4), 32'd1);
        rst = 1'b1;
        #1;
        chk("mrst_valid", 32'(tx_valid), 32'd0);
        chk("mrst_empty", 32'(empty), 32'd1);
        chk("mrst_fcnt", 32'(frame_cnt), 32'd0);
        chk("mrst_ovf", 32'(ovf), 32'd0);
        chk("mrst_data", 32'(tx_data), 32'd0);
        tick();
        rst = 1'b0;
        seen = 1'b0;
        q.delete();
        repeat (400) tick();
        chk("no_resume", 32'(seen), 32'd0);
        chk("no_bytes", 32'(q.size()), 32'd0);
        chk("rel_empty", 32'(empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
